branch_redirect_ctrl: RTL
=========================

Name: branch_redirect_ctrl

Overview:
- Sequences pipeline redirection after branch/jump resolution in the EX stage.
- Consumes the EX branch-decision result (taken/not-taken plus target) and latches the redirect.
- Drives the PC-select mux and flushes the wrong-path instructions in IF/ID and ID/EX for a programmable number of cycles.
- Sits between the EX-stage branch logic and the IF-stage PC mux and pipeline-register flush inputs; static predict-not-taken.

Parameters:
- FLUSH_CYCLES, 2, cycles flush_if_id/flush_id_ex stay asserted per redirect (legal 1..15).
- XLEN, 32, width of PC/target.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- br_valid  in  1  EX stage holds a valid branch/JAL/JALR this cycle.
- br_taken  in  1  branch-decision output from EX (JAL/JALR always 1).
- br_target  in  XLEN  resolved target address from EX ALU.
- stall  in  1  pipeline freeze (memory stall); block holds state while high.
- pc_sel  out  1  1 = PC mux selects pc_target.
- pc_target  out  XLEN  latched redirect address.
- flush_if_id  out  1  clear IF/ID register to NOP.
- flush_id_ex  out  1  clear ID/EX register to NOP.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clocking/reset: one clock CLK; reset is asynchronous and active-low on RESET_N.
- Reset values: all outputs 0, pc_target = 0, state = IDLE, flush counter = 0.
- All outputs are registered. Latency from a taken br_valid edge to pc_sel=1 is 1 cycle.
- States:
  - IDLE: outputs deasserted.
  - REDIRECT: pc_sel=1, both flushes=1, busy=1; lasts exactly one unstalled cycle.
  - FLUSH: pc_sel=0, both flushes=1, busy=1.
- IDLE -> REDIRECT when br_valid & br_taken & !stall. br_target is captured into pc_target on the same edge.
- IDLE stays IDLE when br_valid & !br_taken (not-taken branch: no action) or when stall=1.
- REDIRECT -> FLUSH if FLUSH_CYCLES > 1, loading the counter with FLUSH_CYCLES-1. Otherwise REDIRECT -> IDLE.
- FLUSH:
  - Counter decrements each unstalled cycle.
  - Returns to IDLE on the edge where counter = 1 and stall = 0.
  - br_valid is ignored in REDIRECT and FLUSH; those instructions are wrong-path.
- stall=1 in any state:
  - State, counter, pc_target and all outputs hold.
  - A taken branch seen under stall is not accepted; EX holds it, so it is accepted on the first unstalled cycle.
- Back-to-back: a taken branch on the first unstalled IDLE cycle after a flush sequence is accepted normally.
- pc_target changes only on IDLE -> REDIRECT and stays stable otherwise.
- Async reset mid-sequence: immediate return to reset values. No redirect is replayed after reset release.
- X on br_taken/br_target is don't-care when br_valid=0.

Optional Feature:
- Macro: BRANCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_branches [31:0] and perf_redirects [31:0].
  - perf_branches increments on each accepted br_valid in IDLE with stall=0, taken or not.
  - perf_redirects increments on each IDLE -> REDIRECT transition.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and counters do not exist. Core behaviour is identical either way.

Test Plan:
- Reset: RESET_N=0 mid-FLUSH with pc_target=0x80 -> outputs go to 0 asynchronously (before next CLK edge); stay IDLE after release.
- Taken branch: br_valid=1, br_taken=1, br_target=0x0000_0120, FLUSH_CYCLES=2 -> expected sequence:
  - cycle+1: pc_sel=1, pc_target=0x120, flushes=1.
  - cycle+2: pc_sel=0, flushes=1.
  - cycle+3: all 0.
- Not-taken: br_valid=1, br_taken=0, target 0x200 -> no output change, pc_target keeps its prior value, busy=0.
- Stall during FLUSH: FLUSH_CYCLES=3, stall=1 for 4 cycles after REDIRECT -> flushes stay 1 through the stall, then 2 more unstalled cycles, then IDLE.
- Wrong-path suppression: taken branch to 0x40, then br_valid=1, br_taken=1, target 0x999 during FLUSH -> pc_target stays 0x40, no second REDIRECT.
- Perf counters (BRANCH_PERF_CNT_EN defined): 3 taken branches + 2 not-taken, spaced past flush -> perf_branches=5, perf_redirects=3.

Source files
------------

// File: rtl/branch_redirect_ctrl_if.sv
// rtl/branch_redirect_ctrl_if.sv - EX-branch to IF-redirect handshake bundle
// Optional perf counter signals exist only when BRANCH_PERF_CNT_EN is defined.
interface branch_redirect_ctrl_if #(
   parameter int XLEN = 32
);
   logic            br_valid;
   logic            br_taken;
   logic [XLEN-1:0] br_target;
   logic            stall;
   logic            pc_sel;
   logic [XLEN-1:0] pc_target;
   logic            flush_if_id;
   logic            flush_id_ex;
   logic            busy;
`ifdef BRANCH_PERF_CNT_EN
   logic [31:0]     perf_branches;
   logic [31:0]     perf_redirects;

   modport master (
      output br_valid, br_taken, br_target, stall,
      input  pc_sel, pc_target, flush_if_id, flush_id_ex, busy,
      input  perf_branches, perf_redirects
   );
   modport slave (
      input  br_valid, br_taken, br_target, stall,
      output pc_sel, pc_target, flush_if_id, flush_id_ex, busy,
      output perf_branches, perf_redirects
   );
`else
   modport master (
      output br_valid, br_taken, br_target, stall,
      input  pc_sel, pc_target, flush_if_id, flush_id_ex, busy
   );
   modport slave (
      input  br_valid, br_taken, br_target, stall,
      output pc_sel, pc_target, flush_if_id, flush_id_ex, busy
   );
`endif
endinterface

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - taken-branch PC redirect and wrong-path flush sequencer
// Optional feature macro: BRANCH_PERF_CNT_EN (branch/redirect performance counters).
module branch_redirect_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int XLEN         = 32
) (
   input logic                  CLK,
   input logic                  RESET_N,
   branch_redirect_ctrl_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_FLUSH} state_t;

   localparam logic [3:0] LP_LOAD = 4'(FLUSH_CYCLES - 1);

   state_t          r_state, w_next_state;
   logic [3:0]      r_cnt, w_next_cnt;
   logic [XLEN-1:0] r_pc_target, w_next_target;
   logic            r_pc_sel, w_next_pc_sel;
   logic            r_flush, w_next_flush;
   logic            r_busy, w_next_busy;
   logic            w_accept;

   // Only IDLE listens to EX; anything seen in REDIRECT/FLUSH is wrong-path.
   assign w_accept = (r_state == S_IDLE) && !bus.stall && bus.br_valid && bus.br_taken;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_pc_target <= '0;
         r_pc_sel    <= 1'b0;
         r_flush     <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_cnt       <= w_next_cnt;
         r_pc_target <= w_next_target;
         r_pc_sel    <= w_next_pc_sel;
         r_flush     <= w_next_flush;
         r_busy      <= w_next_busy;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      if (!bus.stall) begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) w_next_state = S_REDIRECT;
            end
            S_REDIRECT: begin
               if (FLUSH_CYCLES > 1) begin
                  w_next_state = S_FLUSH;
                  w_next_cnt   = LP_LOAD;
               end else begin
                  w_next_state = S_IDLE;
               end
            end
            S_FLUSH: begin
               if (r_cnt == 4'd1) begin
                  w_next_state = S_IDLE;
                  w_next_cnt   = 4'd0;
               end else begin
                  w_next_cnt   = r_cnt - 4'd1;
               end
            end
            default: begin
               w_next_state = S_IDLE;
               w_next_cnt   = 4'd0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they land registered with it.
   always_comb begin
      w_next_pc_sel = (w_next_state == S_REDIRECT);
      w_next_flush  = (w_next_state != S_IDLE);
      w_next_busy   = (w_next_state != S_IDLE);
      w_next_target = w_accept ? bus.br_target : r_pc_target;
   end

   assign bus.pc_sel      = r_pc_sel;
   assign bus.pc_target   = r_pc_target;
   assign bus.flush_if_id = r_flush;
   assign bus.flush_id_ex = r_flush;
   assign bus.busy        = r_busy;

`ifdef BRANCH_PERF_CNT_EN
   logic [31:0] r_perf_branches, r_perf_redirects;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_perf_branches  <= 32'd0;
         r_perf_redirects <= 32'd0;
      end else begin
         if ((r_state == S_IDLE) && !bus.stall && bus.br_valid && (r_perf_branches != 32'hFFFF_FFFF))
            r_perf_branches <= r_perf_branches + 32'd1;
         if (w_accept && (r_perf_redirects != 32'hFFFF_FFFF))
            r_perf_redirects <= r_perf_redirects + 32'd1;
      end
   end

   assign bus.perf_branches  = r_perf_branches;
   assign bus.perf_redirects = r_perf_redirects;
`endif
endmodule
